// File: rtl/data_hazard_scoreboard_if.sv
// OF-stage <-> hazard scoreboard signal bundle.
// master drives the OF instruction; slave (the scoreboard) returns the stall/issue decision and status.
interface data_hazard_scoreboard_if #(
  parameter int unsigned PERF_W = 16
) ();
  logic              of_valid;
  logic [31:0]       of_instruction;
  logic              flush;
  logic              of_stall;
  logic              of_issue;
  logic [15:0]       reg_busy;
  logic              flags_busy;
  logic [PERF_W-1:0] stall_cycles;

  modport master (
    output of_valid, of_instruction, flush,
    input  of_stall, of_issue, reg_busy, flags_busy, stall_cycles
  );

  modport slave (
    input  of_valid, of_instruction, flush,
    output of_stall, of_issue, reg_busy, flags_busy, stall_cycles
  );
endinterface

// File: rtl/data_hazard_scoreboard.sv
// Per-register countdown scoreboard deciding stall/issue for the OF-stage instruction.
// Define FORWARDING_EN to relax source readiness to the bypass-network timing.
module data_hazard_scoreboard #(
  parameter int unsigned WB_LATENCY   = 3,
  parameter int unsigned LONG_LATENCY = 6,
  parameter int unsigned CNT_W        = 4,
  parameter int unsigned PERF_W       = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  data_hazard_scoreboard_if.slave  hz
);

  localparam logic [4:0] OP_MUL  = 5'b00010;
  localparam logic [4:0] OP_DIV  = 5'b00011;
  localparam logic [4:0] OP_MOD  = 5'b00100;
  localparam logic [4:0] OP_CMP  = 5'b00101;
  localparam logic [4:0] OP_NOT  = 5'b01000;
  localparam logic [4:0] OP_MOV  = 5'b01001;
  localparam logic [4:0] OP_ASR  = 5'b01100;
  localparam logic [4:0] OP_LD   = 5'b01110;
  localparam logic [4:0] OP_ST   = 5'b01111;
  localparam logic [4:0] OP_BEQ  = 5'b10000;
  localparam logic [4:0] OP_BGT  = 5'b10001;
  localparam logic [4:0] OP_CALL = 5'b10011;
  localparam logic [4:0] OP_RET  = 5'b10100;

  localparam logic [CNT_W-1:0]  LAT_WB   = CNT_W'(WB_LATENCY);
  localparam logic [CNT_W-1:0]  LAT_LONG = CNT_W'(LONG_LATENCY);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [PERF_W-1:0] PERF_ONE = PERF_W'(1);

  logic [4:0] opcode;
  logic       imm;
  logic [3:0] rd;
  logic [3:0] rs1;
  logic [3:0] rs2;
  logic       unused_ins_low;

  assign opcode         = hz.of_instruction[31:27];
  assign imm            = hz.of_instruction[26];
  assign rd             = hz.of_instruction[25:22];
  assign rs1            = hz.of_instruction[21:18];
  assign rs2            = hz.of_instruction[17:14];
  assign unused_ins_low = ^hz.of_instruction[13:0];

  logic       src1_en;
  logic       src2_en;
  logic       src_flags;
  logic       dst_en;
  logic       dst_flags;
  logic       dst_long;
  logic [3:0] src1_idx;
  logic [3:0] src2_idx;
  logic [3:0] dst_idx;

  always_comb begin
    src1_en   = 1'b0;
    src2_en   = 1'b0;
    src_flags = 1'b0;
    dst_en    = 1'b0;
    dst_flags = 1'b0;
    dst_long  = 1'b0;
    src1_idx  = rs1;
    src2_idx  = rs2;
    dst_idx   = rd;
    // ALU group, ld and st all share the rs1/rs2 field layout
    if (opcode <= OP_ASR || opcode == OP_LD || opcode == OP_ST) begin
      src1_en = (opcode != OP_NOT) && (opcode != OP_MOV);
      if (opcode == OP_ST) begin
        src2_en  = 1'b1;
        src2_idx = rd;
      end else begin
        src2_en = ~imm;
      end
      dst_en    = (opcode != OP_CMP) && (opcode != OP_ST);
      dst_flags = (opcode == OP_CMP);
      dst_long  = (opcode == OP_MUL) || (opcode == OP_DIV) || (opcode == OP_MOD);
    end else begin
      case (opcode)
        OP_BEQ, OP_BGT: src_flags = 1'b1;
        OP_CALL: begin
          dst_en  = 1'b1;
          dst_idx = 4'd15;
        end
        OP_RET: begin
          src1_en  = 1'b1;
          src1_idx = 4'd15;
        end
        default: ;
      endcase
    end
  end

  logic [CNT_W-1:0]  cnt_q [16];
  logic [CNT_W-1:0]  cnt_d [16];
  logic [CNT_W-1:0]  cnt_f_q;
  logic [CNT_W-1:0]  cnt_f_d;
  logic [PERF_W-1:0] stall_q;
  logic [PERF_W-1:0] stall_d;

  logic src1_rdy;
  logic src2_rdy;
  logic flags_rdy;

`ifdef FORWARDING_EN
  localparam logic [CNT_W-1:0] LAT_LD = CNT_W'(WB_LATENCY - 1);

  logic [15:0] ld_q;
  logic [15:0] ld_d;
  logic        dst_ld;

  assign dst_ld = (opcode == OP_LD);

  // A load result reaches the bypass one cycle later than an ALU result
  function automatic logic src_ready(input logic [CNT_W-1:0] cnt, input logic from_ld);
    return from_ld ? (cnt <= LAT_LD) : (cnt <= LAT_WB);
  endfunction

  assign src1_rdy  = ~src1_en   | src_ready(cnt_q[src1_idx], ld_q[src1_idx]);
  assign src2_rdy  = ~src2_en   | src_ready(cnt_q[src2_idx], ld_q[src2_idx]);
  assign flags_rdy = ~src_flags | src_ready(cnt_f_q, 1'b0);
`else
  assign src1_rdy  = ~src1_en   | (cnt_q[src1_idx] == '0);
  assign src2_rdy  = ~src2_en   | (cnt_q[src2_idx] == '0);
  assign flags_rdy = ~src_flags | (cnt_f_q == '0);
`endif

  logic [CNT_W-1:0] dst_lat;
  logic             waw;
  logic             live;
  logic             stall;
  logic             issue;

  assign dst_lat = dst_long ? LAT_LONG : LAT_WB;
  // A younger write must never retire ahead of an older one to the same register
  assign waw     = dst_en & (cnt_q[dst_idx] > dst_lat);
  assign live    = hz.of_valid & ~hz.flush;
  assign stall   = live & (~src1_rdy | ~src2_rdy | ~flags_rdy | waw);
  assign issue   = live & ~stall;

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - CNT_ONE : '0;
    end
    cnt_f_d = (cnt_f_q != '0) ? cnt_f_q - CNT_ONE : '0;
    if (issue && dst_en) begin
      cnt_d[dst_idx] = dst_lat;
    end
    if (issue && dst_flags) begin
      cnt_f_d = LAT_WB;
    end
  end

`ifdef FORWARDING_EN
  always_comb begin
    ld_d = ld_q;
    if (issue && dst_en) begin
      ld_d[dst_idx] = dst_ld;
    end
  end
`endif

  assign stall_d = (stall && (stall_q != '1)) ? stall_q + PERF_ONE : stall_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q   <= '{default: '0};
      cnt_f_q <= '0;
      stall_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      cnt_f_q <= cnt_f_d;
      stall_q <= stall_d;
    end
  end

`ifdef FORWARDING_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ld_q <= '0;
    end else begin
      ld_q <= ld_d;
    end
  end
`endif

  logic [15:0] busy;

  always_comb begin
    busy = '0;
    for (int i = 0; i < 16; i++) begin
      busy[i] = (cnt_q[i] != '0);
    end
  end

  assign hz.of_stall     = stall;
  assign hz.of_issue     = issue;
  assign hz.reg_busy     = busy;
  assign hz.flags_busy   = (cnt_f_q != '0);
  assign hz.stall_cycles = stall_q;

endmodule

// File: tb/tb_data_hazard_scoreboard.sv
// Self-checking bench for data_hazard_scoreboard: directed vector table, saturation run and
// randomized stimulus against a completion-time reference model. Honors FORWARDING_EN.
module tb_data_hazard_scoreboard;

  localparam int WB   = 3;
  localparam int LL   = 6;
  localparam int PW   = 6;
  localparam int PMAX = (1 << PW) - 1;

  localparam logic [4:0] ADD = 5'd0;
  localparam logic [4:0] SUB = 5'd1;
  localparam logic [4:0] MUL = 5'd2;
  localparam logic [4:0] CMP = 5'd5;
  localparam logic [4:0] NOP = 5'd13;
  localparam logic [4:0] LD  = 5'd14;
  localparam logic [4:0] BEQ = 5'd16;
  localparam logic [4:0] BR  = 5'd18;

  logic clk = 1'b0;
  logic reset_i = 1'b1;
  always #5 clk = ~clk;

  data_hazard_scoreboard_if #(.PERF_W(PW)) hz ();

  data_hazard_scoreboard #(
    .WB_LATENCY(WB), .LONG_LATENCY(LL), .CNT_W(4), .PERF_W(PW)
  ) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .hz(hz)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: absolute cycle at which each pending write is no longer outstanding.
  int cyc = 0;
  int ready_at [17];
  bit was_ld [17];
  int perf = 0;
  logic act_stall;
  logic act_issue;

  typedef struct {
    logic        rst;
    logic        v;
    logic [31:0] ins;
    logic        fl;
    logic        nf_s, nf_i, fw_s, fw_i;
    logic        clr;
    logic        pchk;
    int          pnf, pfw;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] enc(input logic [4:0] op, input logic imm, input logic [3:0] rd,
                                      input logic [3:0] rs1, input logic [3:0] rs2);
    return {op, imm, rd, rs1, rs2, 14'd0};
  endfunction

  function automatic int rem(input int r);
    return (ready_at[r] > cyc) ? ready_at[r] - cyc : 0;
  endfunction

  function automatic bit src_ok(input int r);
    if (r < 0) return 1'b1;
`ifdef FORWARDING_EN
    return rem(r) <= (was_ld[r] ? WB - 1 : WB);
`else
    return rem(r) == 0;
`endif
  endfunction

  // Register 16 stands for the flags register in the model.
  task automatic m_decode(input logic [31:0] ins, output int s1, output int s2, output int dst,
                          output bit fdst, output int lat, output bit ldw);
    int op;
    int rd;
    op = int'(ins[31:27]);
    rd = int'(ins[25:22]);
    s1 = -1; s2 = -1; dst = -1; fdst = 1'b0;
    lat = (op >= 2 && op <= 4) ? LL : WB;
    ldw = (op == 14);
    if (op <= 12 || op == 14 || op == 15) begin
      if (op != 8 && op != 9) s1 = int'(ins[21:18]);
      if (op == 15) s2 = rd;
      else if (!ins[26]) s2 = int'(ins[17:14]);
      if (op == 5) fdst = 1'b1;
      else if (op != 15) dst = rd;
    end else if (op == 16 || op == 17) begin
      s1 = 16;
    end else if (op == 19) begin
      dst = 15;
    end else if (op == 20) begin
      s1 = 15;
    end
  endtask

  task automatic step(input logic rst, input logic v, input logic [31:0] ins, input logic fl);
    int s1, s2, dst, lat;
    bit fdst, ldw, e_stall, e_issue;
    logic [15:0] e_busy;
    reset_i = rst;
    hz.of_valid = v;
    hz.of_instruction = ins;
    hz.flush = fl;
    @(negedge clk);
    m_decode(ins, s1, s2, dst, fdst, lat, ldw);
    e_stall = v && !fl && (!src_ok(s1) || !src_ok(s2) || (dst >= 0 && rem(dst) > lat));
    e_issue = v && !fl && !e_stall;
    for (int i = 0; i < 16; i++) e_busy[i] = (rem(i) != 0);
    act_stall = hz.of_stall;
    act_issue = hz.of_issue;
    chk("of_stall", 32'(act_stall), 32'(e_stall));
    chk("of_issue", 32'(act_issue), 32'(e_issue));
    chk("reg_busy", 32'(hz.reg_busy), 32'(e_busy));
    chk("flags_busy", 32'(hz.flags_busy), 32'(rem(16) != 0));
    chk("stall_cycles", 32'(hz.stall_cycles), 32'(perf));
    if (rst) begin
      for (int i = 0; i < 17; i++) begin
        ready_at[i] = 0;
        was_ld[i] = 1'b0;
      end
      perf = 0;
    end else begin
      if (e_issue && dst >= 0) begin
        ready_at[dst] = cyc + 1 + lat;
        was_ld[dst] = ldw;
      end
      if (e_issue && fdst) begin
        ready_at[16] = cyc + 1 + WB;
        was_ld[16] = 1'b0;
      end
      if (e_stall && perf < PMAX) perf++;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t row(input logic rst, input logic v, input logic [31:0] ins, input logic fl,
                               input logic nfs, input logic nfi, input logic fws, input logic fwi);
    vec_t r;
    r.rst = rst; r.v = v; r.ins = ins; r.fl = fl;
    r.nf_s = nfs; r.nf_i = nfi; r.fw_s = fws; r.fw_i = fwi;
    r.clr = 1'b0; r.pchk = 1'b0; r.pnf = 0; r.pfw = 0;
    return r;
  endfunction

  function automatic logic [3:0] rnd_reg();
    return ($urandom_range(0, 4) == 4) ? 4'd15 : 4'($urandom_range(0, 3));
  endfunction

  initial begin
    logic [31:0] rins;
    logic [31:0] nop_i;
    logic [31:0] sub_r4;
    logic [31:0] add_r5;
    logic [31:0] add_r7;
    logic [31:0] beq_i;
    nop_i  = enc(NOP, 1'b0, 4'd0, 4'd0, 4'd0);
    sub_r4 = enc(SUB, 1'b0, 4'd4, 4'd1, 4'd5);
    add_r5 = enc(ADD, 1'b0, 4'd5, 4'd2, 4'd6);
    add_r7 = enc(ADD, 1'b0, 4'd7, 4'd3, 4'd4);
    beq_i  = enc(BEQ, 1'b0, 4'd0, 4'd0, 4'd0);
    for (int i = 0; i < 17; i++) begin
      ready_at[i] = 0;
      was_ld[i] = 1'b0;
    end
    hz.of_valid = 1'b0;
    hz.of_instruction = '0;
    hz.flush = 1'b0;
    reset_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // RAW on ALU result
    vecs.push_back(row(1, 0, nop_i, 0, 0, 0, 0, 0));
    vecs.push_back(row(0, 1, enc(ADD, 1'b0, 4'd1, 4'd2, 4'd3), 0, 0, 1, 0, 1));
    vecs.push_back(row(0, 1, sub_r4, 0, 1, 0, 0, 1));
    vecs.push_back(row(0, 1, sub_r4, 0, 1, 0, 0, 1));
    vecs.push_back(row(0, 1, sub_r4, 0, 1, 0, 0, 1));
    vecs.push_back(row(0, 1, sub_r4, 0, 0, 1, 0, 1));
    // load-use
    vecs.push_back(row(1, 0, nop_i, 0, 0, 0, 0, 0));
    vecs.push_back(row(0, 1, enc(LD, 1'b1, 4'd2, 4'd3, 4'd0), 0, 0, 1, 0, 1));
    vecs.push_back(row(0, 1, add_r5, 0, 1, 0, 1, 0));
    vecs.push_back(row(0, 1, add_r5, 0, 1, 0, 0, 1));
    vecs.push_back(row(0, 1, add_r5, 0, 1, 0, 0, 1));
    vecs.push_back(row(0, 1, add_r5, 0, 0, 1, 0, 1));
    vecs[vecs.size()-1].pchk = 1'b1;
    vecs[vecs.size()-1].pnf = 3;
    vecs[vecs.size()-1].pfw = 1;
    // WAW behind a long-latency write
    vecs.push_back(row(1, 0, nop_i, 0, 0, 0, 0, 0));
    vecs.push_back(row(0, 1, enc(MUL, 1'b0, 4'd7, 4'd1, 4'd2), 0, 0, 1, 0, 1));
    vecs.push_back(row(0, 1, add_r7, 0, 1, 0, 1, 0));
    vecs.push_back(row(0, 1, add_r7, 0, 1, 0, 1, 0));
    vecs.push_back(row(0, 1, add_r7, 0, 1, 0, 1, 0));
    vecs.push_back(row(0, 1, add_r7, 0, 0, 1, 0, 1));
    // flags dependency
    vecs.push_back(row(1, 0, nop_i, 0, 0, 0, 0, 0));
    vecs.push_back(row(0, 1, enc(CMP, 1'b0, 4'd0, 4'd1, 4'd2), 0, 0, 1, 0, 1));
    vecs.push_back(row(0, 1, beq_i, 0, 1, 0, 0, 1));
    vecs.push_back(row(0, 1, beq_i, 0, 1, 0, 0, 1));
    vecs.push_back(row(0, 1, beq_i, 0, 1, 0, 0, 1));
    vecs.push_back(row(0, 1, beq_i, 0, 0, 1, 0, 1));
    vecs.push_back(row(0, 1, enc(CMP, 1'b0, 4'd0, 4'd1, 4'd2), 0, 0, 1, 0, 1));
    vecs.push_back(row(0, 1, enc(BR, 1'b0, 4'd0, 4'd0, 4'd0), 0, 0, 1, 0, 1));
    // flush and immediate operand
    vecs.push_back(row(1, 0, nop_i, 0, 0, 0, 0, 0));
    vecs.push_back(row(0, 1, enc(ADD, 1'b0, 4'd1, 4'd2, 4'd3), 0, 0, 1, 0, 1));
    vecs.push_back(row(0, 1, sub_r4, 1, 0, 0, 0, 0));
    vecs.push_back(row(0, 1, sub_r4, 1, 0, 0, 0, 0));
    vecs.push_back(row(0, 1, sub_r4, 0, 1, 0, 0, 1));
    vecs.push_back(row(0, 1, sub_r4, 0, 0, 1, 0, 1));
    vecs.push_back(row(0, 1, enc(ADD, 1'b0, 4'd3, 4'd0, 4'd0), 0, 0, 1, 0, 1));
    vecs.push_back(row(0, 1, enc(ADD, 1'b1, 4'd1, 4'd2, 4'd3), 0, 0, 1, 0, 1));
    // reset with a pending write
    vecs.push_back(row(1, 0, nop_i, 0, 0, 0, 0, 0));
    vecs.push_back(row(0, 1, enc(ADD, 1'b0, 4'd1, 4'd2, 4'd3), 0, 0, 1, 0, 1));
    vecs.push_back(row(0, 1, sub_r4, 0, 1, 0, 0, 1));
    vecs.push_back(row(1, 1, sub_r4, 0, 1, 0, 0, 1));
    vecs[vecs.size()-1].clr = 1'b1;
    vecs.push_back(row(0, 1, sub_r4, 0, 0, 1, 0, 1));

    foreach (vecs[k]) begin
      step(vecs[k].rst, vecs[k].v, vecs[k].ins, vecs[k].fl);
`ifdef FORWARDING_EN
      chk($sformatf("vec%0d_stall", k), 32'(act_stall), 32'(vecs[k].fw_s));
      chk($sformatf("vec%0d_issue", k), 32'(act_issue), 32'(vecs[k].fw_i));
      if (vecs[k].pchk) chk($sformatf("vec%0d_perf", k), 32'(hz.stall_cycles), 32'(vecs[k].pfw));
`else
      chk($sformatf("vec%0d_stall", k), 32'(act_stall), 32'(vecs[k].nf_s));
      chk($sformatf("vec%0d_issue", k), 32'(act_issue), 32'(vecs[k].nf_i));
      if (vecs[k].pchk) chk($sformatf("vec%0d_perf", k), 32'(hz.stall_cycles), 32'(vecs[k].pnf));
`endif
      if (vecs[k].clr) begin
        chk("clr_reg_busy", 32'(hz.reg_busy), 32'd0);
        chk("clr_flags_busy", 32'(hz.flags_busy), 32'd0);
        chk("clr_stall_cycles", 32'(hz.stall_cycles), 32'd0);
      end
    end

    // stall counter saturation on a self-dependent mul chain
    step(1'b1, 1'b0, nop_i, 1'b0);
    for (int n = 0; n < 120; n++) begin
      step(1'b0, 1'b1, enc(MUL, 1'b0, 4'd1, 4'd1, 4'd1), 1'b0);
    end
    chk("perf_saturated", 32'(hz.stall_cycles), 32'(PMAX));

    // randomized traffic on a small register window to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      rins = $urandom;
      rins[31:27] = 5'($urandom_range(0, 23));
      rins[25:22] = rnd_reg();
      rins[21:18] = rnd_reg();
      rins[17:14] = rnd_reg();
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 7) != 0), rins,
           ($urandom_range(0, 7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
